// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: synchronizes, debounces and converts the active-low
// WAIT/START buttons into held levels plus non-overlapping one-cycle press pulses.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button_0,
    input  logic button_1,
    output logic level_0,
    output logic level_1,
    output logic press_0,
    output logic press_1,
    output logic both_held
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    level_q;
    logic [1:0]    level_d;
    logic [1:0]    rise;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          pending;

    // Raw inputs are active-low, so s2 == ~level means the sample agrees with the level.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i] = level_q[i];
            cnt_d[i]   = cnt_q[i];
            if (s2[i] == ~level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = ~level_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        rise = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 2'b11;
            s2        <= 2'b11;
            level_q   <= 2'b00;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            both_held <= 1'b0;
            press_0   <= 1'b0;
            press_1   <= 1'b0;
            pending   <= 1'b0;
        end else begin
            s1        <= {button_1, button_0};
            s2        <= s1;
            level_q   <= level_d;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
            both_held <= level_d[0] & level_d[1];
            press_0   <= rise[0];
            // A START press colliding with a WAIT press is deferred by one cycle.
            press_1   <= (rise[1] & ~rise[0]) | pending;
            pending   <= rise[1] & rise[0];
        end
    end

    assign level_0 = level_q[0];
    assign level_1 = level_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner, checked every cycle against a
// sliding-window reference model of the debounce rules.
module tb_button_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_0 = 1'b1;
    logic button_1 = 1'b1;
    logic level_0, level_1, press_0, press_1, both_held;

    int checks = 0;
    int failures = 0;
    int p0_cnt = 0;
    int p1_cnt = 0;
    int hi_cnt = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .button_0 (button_0),
        .button_1 (button_1),
        .level_0  (level_0),
        .level_1  (level_1),
        .press_0  (press_0),
        .press_1  (press_1),
        .both_held(both_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level flips once the last D synchronized samples (raw delayed two
    // edges, inverted to held-sense) all disagree with it.
    bit [1:0] m_pipe [2];
    bit       m_win  [2][D];
    bit [1:0] m_level;
    bit [1:0] m_press;
    bit [1:0] m_rise;
    bit       m_pend;
    bit       m_both;
    bit       m_all;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_pipe[c] = 2'b00;
                for (int j = 0; j < D; j++) m_win[c][j] = 1'b0;
            end
            m_level = '0;
            m_press = '0;
            m_pend  = 1'b0;
            m_both  = 1'b0;
        end else begin
            m_rise = '0;
            for (int c = 0; c < 2; c++) begin
                for (int j = 0; j < D - 1; j++) m_win[c][j] = m_win[c][j+1];
                m_win[c][D-1] = m_pipe[c][1];
                m_all = 1'b1;
                for (int j = 0; j < D; j++) if (m_win[c][j] == m_level[c]) m_all = 1'b0;
                if (m_all) begin
                    m_level[c] = ~m_level[c];
                    m_rise[c]  = m_level[c];
                end
                m_pipe[c] = {m_pipe[c][0], (c == 0) ? ~button_0 : ~button_1};
            end
            m_press[0] = m_rise[0];
            m_press[1] = (m_rise[1] && !m_rise[0]) || m_pend;
            m_pend     = m_rise[0] && m_rise[1];
            m_both     = m_level[0] && m_level[1];
        end
    end

    always @(negedge clk) begin
        check("level_0", 32'(level_0), 32'(m_level[0]));
        check("level_1", 32'(level_1), 32'(m_level[1]));
        check("press_0", 32'(press_0), 32'(m_press[0]));
        check("press_1", 32'(press_1), 32'(m_press[1]));
        check("both_held", 32'(both_held), 32'(m_both));
        check("press_overlap", 32'(press_0 & press_1), 32'd0);
        if (press_0 === 1'b1) p0_cnt++;
        if (press_1 === 1'b1) p1_cnt++;
        if ({level_0, level_1, press_0, press_1, both_held} !== 5'b0) hi_cnt++;
    end

    task automatic hold(input logic b0, input logic b1, input int n);
        button_0 = b0;
        button_1 = b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        p0_cnt = 0;
        p1_cnt = 0;
        hi_cnt = 0;
    endtask

    int run0, run1;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle: nothing may assert.
        clear_counts();
        hold(1, 1, 100);
        check("idle_outputs", 32'(hi_cnt), 32'd0);

        // Single-cycle glitch rejected.
        clear_counts();
        hold(1, 0, 1);
        hold(1, 1, 12);
        check("glitch_p1", 32'(p1_cnt), 32'd0);
        check("glitch_hi", 32'(hi_cnt), 32'd0);

        // Clean START press and release.
        clear_counts();
        hold(1, 0, 10);
        hold(1, 1, 12);
        check("start_p1", 32'(p1_cnt), 32'd1);
        check("start_p0", 32'(p0_cnt), 32'd0);

        // Bounce then stable low: one press.
        clear_counts();
        hold(1, 0, 2);
        hold(1, 1, 1);
        hold(1, 0, 8);
        hold(1, 1, 12);
        check("bounce_p1", 32'(p1_cnt), 32'd1);

        // Simultaneous press: both pulses, staggered.
        clear_counts();
        hold(0, 0, 10);
        hold(1, 1, 12);
        check("both_p0", 32'(p0_cnt), 32'd1);
        check("both_p1", 32'(p1_cnt), 32'd1);

        // Reset mid-debounce discards progress; press follows later.
        clear_counts();
        hold(0, 1, 4);
        rst = 1'b1;
        hold(0, 1, 1);
        rst = 1'b0;
        hold(0, 1, 10);
        hold(1, 1, 12);
        check("rst_mid_p0", 32'(p0_cnt), 32'd1);

        // Randomized bouncing with occasional resets.
        run0 = 0;
        run1 = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run0 == 0) begin
                button_0 = ~button_0;
                run0 = $urandom_range(1, 12);
            end
            if (run1 == 0) begin
                button_1 = ~button_1;
                run1 = $urandom_range(1, 12);
            end
            run0--;
            run1--;
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        hold(1, 1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
